// File: rtl/instr_prefetch_buf.sv
// Instruction prefetch buffer: streams sequential words into a DEPTH-entry FIFO ahead of the core.
// Optional PREFETCH_STATS_EN adds saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module instr_prefetch_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pc_req_i,
  input  logic [31:0] pc_addr_i,
  output logic [31:0] pc_data_o,
  output logic        pc_ready_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ready_i
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_e;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  state_e        state_q, state_d;
  entry_t        fifo_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d, cnt_upd;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          flushed_q, flushed_d;

  logic [31:0] req_addr, pend_addr;
  entry_t      head;
  logic        empty, hit, pend, miss, redir, push, pop;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^pc_addr_i[1:0];
  assign req_addr  = {pc_addr_i[31:2], 2'b00};
  assign empty     = (cnt_q == '0);
  assign head      = fifo_q[rd_ptr_q];
  assign hit       = pc_req_i & ~flush_i & ~empty & (head.addr == req_addr);
  // An empty buffer already working on the requested word is not a miss;
  // otherwise a core holding its request would keep restarting the fetch.
  assign pend_addr = (state_q == FETCH) ? mem_addr_q : fetch_addr_q;
  assign pend      = empty & ~flushed_q & (pend_addr == req_addr);
  assign miss      = pc_req_i & ~flush_i & ~hit & ~pend;
  assign redir     = miss | flush_i;
  assign push      = (state_q == FETCH) & mem_ready_i & ~redir;
  assign pop       = hit;
  assign cnt_upd   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!redir && !flushed_q && cnt_q < FULL) state_d = FETCH;
      FETCH: begin
        if (mem_ready_i)  state_d = (!redir && cnt_upd < FULL) ? FETCH : IDLE;
        else if (redir)   state_d = DISCARD;
      end
      DISCARD: if (mem_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_req_o  = (state_q != IDLE);
    mem_addr_o = mem_addr_q;
    pc_ready_o = hit;
    pc_data_o  = hit ? head.data : 32'h0;
  end

  // Datapath next-state
  always_comb begin
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    cnt_d        = cnt_upd;
    fetch_addr_d = push ? fetch_addr_q + 32'd4 : fetch_addr_q;
    flushed_d    = flushed_q;
    mem_addr_d   = mem_addr_q;
    if (redir) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      if (pc_req_i) begin
        fetch_addr_d = req_addr;
        flushed_d    = 1'b0;
      end else begin
        flushed_d    = 1'b1;
      end
    end
    // Bus address only moves when a new request is issued; held through DISCARD.
    if (state_d == FETCH && (state_q == IDLE || push)) mem_addr_d = fetch_addr_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      fetch_addr_q <= RESET_PC;
      mem_addr_q   <= 32'h0;
      flushed_q    <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
      flushed_q    <= flushed_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= '{addr: mem_addr_q, data: mem_data_i};
  end

`ifdef PREFETCH_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      if (hit  && hit_cnt_q  != 32'hFFFF_FFFF) hit_cnt_q  <= hit_cnt_q  + 32'd1;
      if (miss && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
